lpc_host: RTL
=============

// Module: lpc_host
// PURPOSE
//  LPC host (initiator) issuing single-byte I/O read/write cycles on LAD[3:0]/LFRAME#.
//  It is the other end of the bus from lpc_dev: it drives lpc_dev on the bench and
//  lets the board talk to LPC peripherals.
//  A simple request/response port accepts one transaction at a time.
//  All timing is in LPC_CLK cycles.
// PARAMETERS
//  MAX_WAIT  32  max SYNC sample cycles without ready/error before abort (>=3)
// PORTS
//  LPC_CLK    in   1   LPC clock; all logic on rising edge
//  LPC_RST    in   1   synchronous reset, active-high
//  LAD_OUT    out  4   nibble driven onto LAD when LAD_OE=1
//  LAD_OE     out  1   1 = host drives LAD; 0 = tri-state (top-level ties to pads)
//  LAD_IN     in   4   LAD pad value, sampled on rising edge
//  LPC_FRAME  out  1   LFRAME#, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   1 only in IDLE; request accepted when req_valid&req_ready
//  req_write  in   1   1 = I/O write, 0 = I/O read
//  req_addr   in   16  I/O address
//  req_wdata  in   8   write data
//  rsp_valid  out  1   one-cycle pulse at transaction end
//  rsp_rdata  out  8   read data; held until next rsp_valid; 0 for writes/aborts
//  rsp_error  out  1   SYNC error (1010) or timeout abort; valid with rsp_valid
//  rsp_tmo    out  1   timeout abort; valid with rsp_valid
// BEHAVIOUR
//  Reset: LAD_OE=0, LAD_OUT=4'hF, LPC_FRAME=1, req_ready=1, rsp_valid=0,
//   rsp_rdata=0, rsp_error=0, rsp_tmo=0, state IDLE, wait count 0.
//  LPC_RST asserted mid-transaction: IDLE on next edge with reset values; no rsp_valid.
//  Request inputs are captured at accept; later changes are ignored.
//  Accept at edge T. States and LAD values (host drives unless noted):
//   START   T+1     FRAME=0, LAD=0000
//   CYCTYP  T+2     LAD=0000 (read) / 0010 (write)
//   ADDR    T+3..6  addr[15:12],[11:8],[7:4],[3:0]
//   WDATA   T+7..8  write only: wdata[3:0], then wdata[7:4]
//   HTAR1   1 cyc   LAD=1111; HTAR2 1 cyc: LAD_OE=0
//   SYNC    >=1 cyc LAD_OE=0; sample LAD_IN each cycle:
//           0000 -> next; 1010 -> next and set error flag;
//           any other value (0101, 0110, 1111, ...) -> wait, count++
//   RDATA   2 cyc   read only: sample low nibble, then high nibble
//   TTAR    2 cyc   target turnaround; LAD_OE=0
//   DONE    1 cyc   rsp_valid=1, req_ready=1 (IDLE entered at same edge)
//  Zero-wait latency: rsp_valid at T+14 for both read and write; +1 per wait cycle.
//  A new request may be accepted in the rsp_valid cycle; its START is the next cycle.
//  FRAME=0 only in START (and ABORT); LAD_OE=1 only in START..HTAR1 (and ABORT).
//  Timeout: count reaches MAX_WAIT in SYNC -> ABORT: 4 cycles FRAME=0, LAD_OE=1,
//   LAD=1111; then 1 idle cycle (FRAME=1, OE=0); then DONE with rsp_error=1,
//   rsp_tmo=1, rsp_rdata=0.
//  rsp_error from SYNC=1010: read data phase still runs and data is returned;
//   rsp_error=1, rsp_tmo=0.
//  Wait counter clears on every accept; MAX_WAIT-1 waits then 0000 completes normally.
// TESTING
//  Write 0x03F8<=0xA5, target SYNC 0000 at once -> LAD seq 0,2,0,3,F,8,5,A,F; rsp at T+14, err=0
//  Read 0x02F8, target SYNC 0000, data 0x3C (C then 3) -> rsp_rdata=0x3C at T+14, err=0
//  Read with 5 SYNC=0110 before 0000 -> rsp_valid at T+19, data correct
//  No target (LAD_IN=1111) -> after MAX_WAIT, 4-cycle FRAME=0 abort; rsp err=1, tmo=1, rdata=0
//  SYNC=1010 on read with data 0x77 -> rsp_rdata=0x77, err=1, tmo=0
//  LPC_RST during ADDR -> next cycle FRAME=1, OE=0, req_ready=1; no rsp_valid; next request OK
//  Back-to-back: req_valid held through rsp_valid -> second START the cycle after rsp_valid
//  With lpc_dev: write 0x41 to its UART port -> byte appears on UART_TX

Source files
------------

// File: rtl/lpc_host.sv
// rtl/lpc_host.sv - LPC host issuing single-byte I/O read/write cycles
//
// Purpose: accepts one request at a time and runs it on LAD[3:0]/LFRAME#.
// The host drives START, CYCTYP, ADDR, WDATA (writes only) and HTAR1. It
// releases LAD for HTAR2 and then waits in SYNC for the target. Reads then
// capture two data nibbles. A target turnaround follows, then a one-cycle
// response.
// If SYNC sees no ready or error for MAX_WAIT samples, the cycle is aborted
// with four LFRAME# low cycles.
//
// Ports:
//   LPC_CLK, LPC_RST      clock, synchronous active-high reset
//   LAD_OUT/LAD_OE/LAD_IN split LAD pad: host nibble, host enable, pad value
//   LPC_FRAME             LFRAME#, active-low
//   req_*                 request: valid/ready handshake, write flag, addr, wdata
//   rsp_*                 response: one-cycle valid, rdata, error, timeout flag
module lpc_host #(
  parameter int MAX_WAIT = 32
) (
  input  logic        LPC_CLK,
  input  logic        LPC_RST,
  output logic [3:0]  LAD_OUT,
  output logic        LAD_OE,
  input  logic [3:0]  LAD_IN,
  output logic        LPC_FRAME,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_tmo
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYP, S_ADDR, S_WDATA, S_HTAR1, S_HTAR2,
    S_SYNC, S_RDATA, S_TTAR, S_ABORT, S_ABORT_IDLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;       // nibble / cycle index within a multi-cycle phase
  logic [WW-1:0] wait_q, wait_d;     // SYNC samples without ready/error
  logic          write_q, write_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    data_q, data_d;     // read data being assembled
  logic          err_q, err_d;       // SYNC error seen in this transaction
  logic [7:0]    rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic          rtmo_q, rtmo_d;

  logic accept;

  // DONE doubles as an idle cycle so a new request can be taken alongside rsp_valid.
  assign req_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_error = rerr_q;
  assign rsp_tmo   = rtmo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    rtmo_d    = rtmo_q;
    LAD_OUT   = 4'hF;
    LAD_OE    = 1'b0;
    LPC_FRAME = 1'b1;

    case (state_q)
      S_IDLE: ;
      S_START: begin
        LPC_FRAME = 1'b0;
        LAD_OE    = 1'b1;
        LAD_OUT   = 4'h0;
        state_d   = S_CYCTYP;
      end
      S_CYCTYP: begin
        LAD_OE  = 1'b1;
        LAD_OUT = write_q ? 4'h2 : 4'h0;
        cnt_d   = 2'd0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        LAD_OE = 1'b1;
        case (cnt_q)
          2'd0:    LAD_OUT = addr_q[15:12];
          2'd1:    LAD_OUT = addr_q[11:8];
          2'd2:    LAD_OUT = addr_q[7:4];
          default: LAD_OUT = addr_q[3:0];
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = write_q ? S_WDATA : S_HTAR1;
        end
      end
      S_WDATA: begin
        // LPC sends the low nibble of data first.
        LAD_OE  = 1'b1;
        LAD_OUT = cnt_q[0] ? wdata_q[7:4] : wdata_q[3:0];
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q[0]) begin
          cnt_d   = 2'd0;
          state_d = S_HTAR1;
        end
      end
      S_HTAR1: begin
        LAD_OE  = 1'b1;
        LAD_OUT = 4'hF;
        state_d = S_HTAR2;
      end
      S_HTAR2: state_d = S_SYNC;
      S_SYNC: begin
        cnt_d = 2'd0;
        if (LAD_IN == 4'b0000 || LAD_IN == 4'b1010) begin
          if (LAD_IN == 4'b1010) err_d = 1'b1;
          state_d = write_q ? S_TTAR : S_RDATA;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ABORT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_RDATA: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q[0]) begin
          data_d[7:4] = LAD_IN;
          cnt_d       = 2'd0;
          state_d     = S_TTAR;
        end else begin
          data_d[3:0] = LAD_IN;
        end
      end
      S_TTAR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q[0]) begin
          cnt_d   = 2'd0;
          state_d = S_DONE;
          rdata_d = write_q ? 8'h00 : data_q;
          rerr_d  = err_q;
          rtmo_d  = 1'b0;
        end
      end
      S_ABORT: begin
        LPC_FRAME = 1'b0;
        LAD_OE    = 1'b1;
        LAD_OUT   = 4'hF;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = S_ABORT_IDLE;
        end
      end
      S_ABORT_IDLE: begin
        state_d = S_DONE;
        rdata_d = 8'h00;
        rerr_d  = 1'b1;
        rtmo_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture after the case so an accept in DONE overrides its return to IDLE.
    if (accept) begin
      state_d = S_START;
      cnt_d   = 2'd0;
      wait_d  = '0;
      err_d   = 1'b0;
      data_d  = 8'h00;
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
  end

  always_ff @(posedge LPC_CLK) begin
    if (LPC_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      wait_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      rerr_q  <= 1'b0;
      rtmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rtmo_q  <= rtmo_d;
    end
  end

endmodule
